pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives the enable and bubble-insert controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates between instruction-memory stalls, data-memory stalls, load-use hazards, taken branches/jumps and halt.
- Sequences the halt drain so the processor stops only after the halt instruction retires in WB.
- Keeps a stall-cycle counter and flags a stuck data memory.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StDmemWait = 2'd1,
    StDrain    = 2'd2,
    StHalted   = 2'd3
  } hz_state_e;

  localparam int unsigned DefaultMaxWait = 64;

  typedef struct packed {
    logic pc_en;
    logic en_fd;
    logic flush_fd;
    logic en_dx;
    logic flush_dx;
    logic en_xm;
    logic en_mw;
  } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear wins over enable).
module pipe_hazard_ctrl_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard arbitration, halt drain,
// stall-cycle accounting and stuck data-memory detection.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = DefaultMaxWait
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instMemStall,
  input  logic             dataMemStall,
  input  logic             loadUse,
  input  logic             redirect,
  input  logic             haltID,
  input  logic             haltWB,
  output logic             pcEn,
  output logic             en_FD,
  output logic             flush_FD,
  output logic             en_DX,
  output logic             flush_DX,
  output logic             en_XM,
  output logic             en_MW,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stallCycles
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  hz_state_e        state_q, state_d;
  hz_ctrl_t         ctrl;
  logic             err_q, err_d;
  logic             in_drain, active;
  logic             dmem_stall_cyc, count_stall;
  logic [WaitW-1:0] wait_cnt;

  assign in_drain = (state_q == StDrain);
  assign active   = (state_q != StHalted);

  always_comb begin
    ctrl    = '{pc_en: 1'b1, en_fd: 1'b1, flush_fd: 1'b0, en_dx: 1'b1,
                flush_dx: 1'b0, en_xm: 1'b1, en_mw: 1'b1};
    state_d = state_q;
    if (!active) begin
      ctrl = '0;
    end else if (dataMemStall) begin
      // MEM/WB still advances; the datapath masks the write so it holds a bubble.
      ctrl    = '{pc_en: 1'b0, en_fd: 1'b0, flush_fd: 1'b0, en_dx: 1'b0,
                  flush_dx: 1'b0, en_xm: 1'b0, en_mw: 1'b1};
      state_d = in_drain ? StDrain : StDmemWait;
    end else begin
      if (redirect) begin
        ctrl.flush_fd = 1'b1;
        ctrl.flush_dx = 1'b1;
      end else if (loadUse) begin
        ctrl.pc_en    = 1'b0;
        ctrl.en_fd    = 1'b0;
        ctrl.flush_dx = 1'b1;
      end else if (haltID || in_drain || instMemStall) begin
        ctrl.pc_en    = 1'b0;
        ctrl.flush_fd = 1'b1;
      end
      if (in_drain) begin
        ctrl.pc_en = 1'b0;
      end
      if (in_drain || (haltID && !redirect && !loadUse)) begin
        state_d = StDrain;
      end else begin
        state_d = StRun;
      end
    end
    // A halt retiring in WB stops the core unless a data access is still pending.
    if (active && haltWB && !((state_q == StDmemWait) && dataMemStall)) begin
      state_d = StHalted;
    end
    if (rst) begin
      ctrl = '0;
    end
  end

  assign dmem_stall_cyc = active && dataMemStall;
  assign count_stall    = !ctrl.pc_en && ((state_q == StRun) || (state_q == StDmemWait));
  assign err_d          = err_q || (wait_cnt == WaitW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  pipe_hazard_ctrl_sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (count_stall),
    .clr  (1'b0),
    .count(stallCycles)
  );

  pipe_hazard_ctrl_sat_counter #(
    .Width(WaitW)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (dmem_stall_cyc),
    .clr  (!dmem_stall_cyc),
    .count(wait_cnt)
  );

  assign pcEn     = ctrl.pc_en;
  assign en_FD    = ctrl.en_fd;
  assign flush_FD = ctrl.flush_fd;
  assign en_DX    = ctrl.en_dx;
  assign flush_DX = ctrl.flush_dx;
  assign en_XM    = ctrl.en_xm;
  assign en_MW    = ctrl.en_mw;
  assign halted   = !rst && (state_q == StHalted);
  assign err      = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed vector table, err/reset sequences, random run vs model.
module tb_pipe_hazard_ctrl;

  localparam int MaxWait = 64;
  localparam int CntW    = 16;
  localparam int MRun = 0, MWait = 1, MDrain = 2, MHalt = 3;

  // Control vector order: {pcEn, en_FD, flush_FD, en_DX, flush_DX, en_XM, en_MW}
  localparam logic [6:0] CNorm  = 7'b1101011;
  localparam logic [6:0] CRedir = 7'b1111111;
  localparam logic [6:0] CLoadU = 7'b0001111;
  localparam logic [6:0] CNoFet = 7'b0111011;
  localparam logic [6:0] CDStal = 7'b0000001;
  localparam logic [6:0] COff   = 7'b0000000;

  // Input vector order: {instMemStall, dataMemStall, loadUse, redirect, haltID, haltWB}
  localparam logic [5:0] IIdle = 6'b000000;
  localparam logic [5:0] IIms  = 6'b100000;
  localparam logic [5:0] IDms  = 6'b010000;
  localparam logic [5:0] ILu   = 6'b001000;
  localparam logic [5:0] IRdLu = 6'b001100;
  localparam logic [5:0] IHid  = 6'b000010;
  localparam logic [5:0] IHwb  = 6'b000001;
  localparam logic [5:0] IImRd = 6'b100100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instMemStall = 1'b0, dataMemStall = 1'b0, loadUse = 1'b0;
  logic redirect = 1'b0, haltID = 1'b0, haltWB = 1'b0;
  logic pcEn, en_FD, flush_FD, en_DX, flush_DX, en_XM, en_MW, halted, err;
  logic [CntW-1:0] stallCycles;

  int checks = 0;
  int failures = 0;

  int m_mode = MRun;
  int m_sc   = 0;
  int m_wait = 0;
  bit m_err  = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .CNT_W   (CntW),
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instMemStall(instMemStall),
    .dataMemStall(dataMemStall),
    .loadUse     (loadUse),
    .redirect    (redirect),
    .haltID      (haltID),
    .haltWB      (haltWB),
    .pcEn        (pcEn),
    .en_FD       (en_FD),
    .flush_FD    (flush_FD),
    .en_DX       (en_DX),
    .flush_DX    (flush_DX),
    .en_XM       (en_XM),
    .en_MW       (en_MW),
    .halted      (halted),
    .err         (err),
    .stallCycles (stallCycles)
  );

  function automatic logic [6:0] dut_ctrl();
    return {pcEn, en_FD, flush_FD, en_DX, flush_DX, en_XM, en_MW};
  endfunction

  // Expected controls straight from the priority rules.
  function automatic logic [6:0] exp_ctrl(int mode, logic r, logic [5:0] v);
    logic [6:0] c;
    if (r || mode == MHalt) return COff;
    if (v[4]) return CDStal;
    if (v[2]) c = CRedir;
    else if (v[3]) c = CLoadU;
    else if ((v[1] && mode != MDrain) || mode == MDrain || v[5]) c = CNoFet;
    else c = CNorm;
    if (mode == MDrain) c[6] = 1'b0;
    return c;
  endfunction

  task automatic model_step(logic r, logic [5:0] v);
    logic [6:0] c;
    if (r) begin
      m_mode = MRun; m_sc = 0; m_wait = 0; m_err = 1'b0;
      return;
    end
    c = exp_ctrl(m_mode, r, v);
    if (!c[6] && (m_mode == MRun || m_mode == MWait) && m_sc < (1 << CntW) - 1) m_sc++;
    if (m_wait == MaxWait) m_err = 1'b1;
    if (m_mode != MHalt && v[4]) m_wait = (m_wait < 127) ? m_wait + 1 : 127;
    else m_wait = 0;
    if (m_mode == MHalt) return;
    if (v[0] && !(m_mode == MWait && v[4])) m_mode = MHalt;
    else if (v[4]) m_mode = (m_mode == MDrain) ? MDrain : MWait;
    else if (m_mode == MDrain) m_mode = MDrain;
    else if (v[1] && !v[2] && !v[3]) m_mode = MDrain;
    else m_mode = MRun;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; return at the following negedge.
  task automatic drive(logic r, logic [5:0] v);
    @(posedge clk);
    #1;
    rst = r;
    {instMemStall, dataMemStall, loadUse, redirect, haltID, haltWB} = v;
    @(negedge clk);
  endtask

  task automatic step_model_check(string tag, logic r, logic [5:0] v);
    drive(r, v);
    chk({tag, "_ctrl"}, 32'(dut_ctrl()), 32'(exp_ctrl(m_mode, r, v)));
    chk({tag, "_halted"}, 32'(halted), 32'(!r && m_mode == MHalt));
    chk({tag, "_stall"}, 32'(stallCycles), 32'(m_sc));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    model_step(r, v);
  endtask

  typedef struct {
    logic [5:0] in;
    logic [6:0] ctrl;
    logic       hlt;
    int         sc;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [5:0] v;
    logic       r;

    vecs[0]  = '{IIdle, CNorm,  1'b0, 0};
    vecs[1]  = '{ILu,   CLoadU, 1'b0, 0};
    vecs[2]  = '{IIdle, CNorm,  1'b0, 1};
    vecs[3]  = '{IDms,  CDStal, 1'b0, 1};
    vecs[4]  = '{IDms,  CDStal, 1'b0, 2};
    vecs[5]  = '{IDms,  CDStal, 1'b0, 3};
    vecs[6]  = '{IIdle, CNorm,  1'b0, 4};
    vecs[7]  = '{IRdLu, CRedir, 1'b0, 4};
    vecs[8]  = '{IIdle, CNorm,  1'b0, 4};
    vecs[9]  = '{IIms,  CNoFet, 1'b0, 4};
    vecs[10] = '{IIdle, CNorm,  1'b0, 5};
    vecs[11] = '{IHid,  CNoFet, 1'b0, 5};
    vecs[12] = '{IDms,  CDStal, 1'b0, 6};
    vecs[13] = '{IDms,  CDStal, 1'b0, 6};
    vecs[14] = '{IIdle, CNoFet, 1'b0, 6};
    vecs[15] = '{IHwb,  CNoFet, 1'b0, 6};
    vecs[16] = '{IIdle, COff,   1'b1, 6};
    vecs[17] = '{IImRd, COff,   1'b1, 6};

    // Reset held for two cycles: everything gated off.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, IIdle);
      chk("rst_ctrl", 32'(dut_ctrl()), 32'(COff));
      model_step(1'b1, IIdle);
    end

    // Directed test-plan sequence.
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, vecs[i].in);
      chk($sformatf("vec%0d_ctrl", i), 32'(dut_ctrl()), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].hlt));
      chk($sformatf("vec%0d_stall", i), 32'(stallCycles), 32'(vecs[i].sc));
    end

    // Halted persists until reset; reset brings back a clean run state.
    drive(1'b1, IIdle);
    drive(1'b0, IIdle);
    chk("post_halt_ctrl", 32'(dut_ctrl()), 32'(CNorm));
    chk("post_halt_halted", 32'(halted), 32'(0));
    chk("post_halt_stall", 32'(stallCycles), 32'(0));

    // Data-memory stall one short of the limit: no error.
    for (int i = 0; i < MaxWait - 1; i++) drive(1'b0, IDms);
    drive(1'b0, IIdle);
    chk("wait63_ctrl", 32'(dut_ctrl()), 32'(CNorm));
    chk("wait63_stall", 32'(stallCycles), 32'(MaxWait - 1));
    drive(1'b0, IIdle);
    chk("wait63_err", 32'(err), 32'(0));

    // Stall past the limit: err rises while stalled and stays after.
    for (int i = 0; i < MaxWait + 2; i++) drive(1'b0, IDms);
    chk("wait66_err", 32'(err), 32'(1));
    chk("wait66_ctrl", 32'(dut_ctrl()), 32'(CDStal));
    drive(1'b0, IIdle);
    chk("wait66_exit_ctrl", 32'(dut_ctrl()), 32'(CNorm));
    drive(1'b0, IIdle);
    chk("wait66_sticky", 32'(err), 32'(1));
    chk("wait66_stall", 32'(stallCycles), 32'(2 * MaxWait + 1));

    // Reset in the middle of a data-memory wait clears everything.
    drive(1'b0, IDms);
    drive(1'b0, IDms);
    drive(1'b1, IDms);
    drive(1'b0, IIdle);
    chk("rst_wait_ctrl", 32'(dut_ctrl()), 32'(CNorm));
    chk("rst_wait_err", 32'(err), 32'(0));
    chk("rst_wait_stall", 32'(stallCycles), 32'(0));

    // Reset during drain returns to normal fetch.
    drive(1'b0, IHid);
    drive(1'b0, IIdle);
    chk("drain_ctrl", 32'(dut_ctrl()), 32'(CNoFet));
    drive(1'b1, IIdle);
    drive(1'b0, IIdle);
    chk("rst_drain_ctrl", 32'(dut_ctrl()), 32'(CNorm));

    // Randomized run against the reference model.
    step_model_check("rnd_rst", 1'b1, IIdle);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 59) == 0);
      v[5] = ($urandom_range(0, 5) == 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = ($urandom_range(0, 5) == 0);
      v[2] = ($urandom_range(0, 6) == 0);
      v[1] = ($urandom_range(0, 12) == 0);
      v[0] = ($urandom_range(0, 40) == 0);
      step_model_check("rnd", r, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
